// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit_if
// Description : Request/response bundle between the execute stage and the
//               iterative RV32M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic            we_out;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] result;

    // Core / pipeline side
    modport master (
        output start, flush, funct3, op_a, op_b, rd_in,
        input  busy, done, we_out, rd_out, result
    );

    // Multiply/divide unit side
    modport slave (
        input  start, flush, funct3, op_a, op_b, rd_in,
        output busy, done, we_out, rd_out, result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative RV32M multiply/divide unit. Radix-2 shift-add
//               multiply and restoring divide, one bit per cycle, with
//               single-cycle handling of divide-by-zero and signed overflow.
//               All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  wire logic     clk,
    input  wire logic     rst,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] C_INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] C_ONES    = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand or divisor magnitude
    logic              neg_q, neg_d;       // negate the final result
    logic [2:0]        f3_q, f3_d;
    logic [4:0]        rd_lat_q, rd_lat_d; // destination of the in-flight op
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              we_q, we_d;
    logic [4:0]        rd_out_q, rd_out_d;
    logic [XLEN-1:0]   result_q, result_d;

    // ---------------- operand preparation at issue ----------------
    logic            a_signed, b_signed, sa, sb, div_op, b_zero, ovf;
    logic [XLEN-1:0] mag_a, mag_b, special_val;
    logic            neg_start;

    assign a_signed  = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) &&
                       (bus.funct3 != 3'b111);
    assign b_signed  = a_signed && (bus.funct3 != 3'b010);
    assign sa        = a_signed && bus.op_a[XLEN-1];
    assign sb        = b_signed && bus.op_b[XLEN-1];
    assign mag_a     = sa ? -bus.op_a : bus.op_a;
    assign mag_b     = sb ? -bus.op_b : bus.op_b;
    assign div_op    = bus.funct3[2];
    // Remainder follows the dividend sign; products and quotients the XOR.
    assign neg_start = (div_op && bus.funct3[1]) ? sa : (sa ^ sb);
    assign b_zero    = div_op && (bus.op_b == '0);
    assign ovf       = div_op && !bus.funct3[0] &&
                       (bus.op_a == C_INT_MIN) && (bus.op_b == C_ONES);
    assign special_val = b_zero ? (bus.funct3[1] ? bus.op_a : C_ONES)
                                : (bus.funct3[1] ? '0 : bus.op_a);

    // ---------------- one iteration step ----------------
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ok;
    logic [2*XLEN-1:0] mul_next, div_next, step, prod;
    logic [XLEN-1:0]   mul_res, div_val, div_res, final_val;

    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                       (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign div_ok    = !div_diff[XLEN];
    assign div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_q[XLEN-2:0], div_ok};
    assign step      = f3_q[2] ? div_next : mul_next;

    // Sign correction applied to the value produced by the final step
    assign prod      = neg_q ? -step : step;
    assign mul_res   = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    assign div_val   = f3_q[1] ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    assign div_res   = neg_q ? -div_val : div_val;
    assign final_val = f3_q[2] ? div_res : mul_res;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        neg_d    = neg_q;
        f3_d     = f3_q;
        rd_lat_d = rd_lat_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    f3_d     = bus.funct3;
                    neg_d    = neg_start;
                    rd_lat_d = bus.rd_in;
                    cnt_d    = CW'(XLEN-1);
                    opnd_d   = div_op ? mag_b : mag_a;
                    acc_d    = {{XLEN{1'b0}}, (div_op ? mag_a : mag_b)};
                    if (b_zero || ovf) begin
                        state_d  = S_DONE;
                        result_d = special_val;
                        rd_out_d = bus.rd_in;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = step;
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = final_val;
                        rd_out_d = rd_lat_q;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        we_d   = done_d && (rd_out_d != 5'd0);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            f3_q     <= '0;
            rd_lat_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            rd_out_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            neg_q    <= neg_d;
            f3_q     <= f3_d;
            rd_lat_q <= rd_lat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            rd_out_q <= rd_out_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.we_out = we_q;
    assign bus.rd_out = rd_out_q;
    assign bus.result = result_q;
endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit: directed operations push
//               expected responses; a monitor pops and compares on done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd  = '0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we;
        int          at;
    } exp_t;
    exp_t sb[$];

    muldiv_unit_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Cycle count used to check start-to-done latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        ncmp++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input int lat,
                         input bit expect_done);
        exp_t e;
        @(negedge clk);
        bus.funct3 = f3; bus.op_a = a; bus.op_b = b; bus.rd_in = rd; bus.start = 1'b1;
        if (expect_done) begin
            e.res = res; e.rd = rd; e.we = (rd != 5'd0); e.at = cyc + lat;
            sb.push_back(e);
            last_res = res; last_rd = rd;
        end
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_issue", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            ncmp++; nfail++;
            $display("FAIL wait_idle: timeout, got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
        bus.op_a = '0; bus.op_b = '0; bus.rd_in = '0;

        // Monitor: every done must match the oldest outstanding expectation
        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.done) begin
                    if (sb.size() == 0) begin
                        ncmp++; nfail++;
                        $display("FAIL unexpected_done: got result 0x%08h expected no done", bus.result);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("result", bus.result, e.res);
                        check("rd_out", {27'd0, bus.rd_out}, {27'd0, e.rd});
                        check("we_out", {31'd0, bus.we_out}, {31'd0, e.we});
                        check("latency", cyc, e.at);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, bus.busy},   32'd0);
        check("rst_done",   {31'd0, bus.done},   32'd0);
        check("rst_result", bus.result,          32'd0);
        check("rst_rd",     {27'd0, bus.rd_out}, 32'd0);
        rst = 1'b0;

        // Multiply
        issue(3'b000, 32'd7,        32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 33, 1'b1); wait_idle();
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 33, 1'b1); wait_idle();
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 33, 1'b1); wait_idle();
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 33, 1'b1); wait_idle();
        // Divide
        issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 33, 1'b1); wait_idle();
        issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 33, 1'b1); wait_idle();
        issue(3'b101, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1'b1); wait_idle();
        issue(3'b111, 32'd100, 32'd7, 5'd8, 32'd2,  33, 1'b1); wait_idle();
        // Special cases, back to back
        issue(3'b100, 32'd5, 32'd0, 5'd9,  32'hFFFF_FFFF, 1, 1'b1);
        issue(3'b110, 32'd5, 32'd0, 5'd10, 32'd5,        1, 1'b1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, 1'b1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,        1, 1'b1);
        wait_idle();
        // rd = 0 suppresses the write
        issue(3'b000, 32'd6, 32'd7, 5'd0, 32'd42, 33, 1'b1); wait_idle();

        // start during CALC is ignored
        issue(3'b101, 32'd100, 32'd7, 5'd13, 32'd14, 33, 1'b1);
        repeat (9) @(negedge clk);
        bus.funct3 = 3'b000; bus.op_a = 32'd3; bus.op_b = 32'd3; bus.rd_in = 5'd14;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (40) @(negedge clk);

        // flush mid-CALC: no done, outputs hold
        issue(3'b101, 32'd1000, 32'd10, 5'd15, 32'd0, 0, 1'b0);
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy",   {31'd0, bus.busy},   32'd0);
        check("flush_done",   {31'd0, bus.done},   32'd0);
        check("flush_result", bus.result,          last_res);
        check("flush_rd",     {27'd0, bus.rd_out}, {27'd0, last_rd});
        repeat (40) @(negedge clk);

        // asynchronous reset between edges mid-CALC
        issue(3'b000, 32'd9, 32'd9, 5'd16, 32'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy",   {31'd0, bus.busy},   32'd0);
        check("arst_done",   {31'd0, bus.done},   32'd0);
        check("arst_we",     {31'd0, bus.we_out}, 32'd0);
        check("arst_result", bus.result,          32'd0);
        check("arst_rd",     {27'd0, bus.rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(3'b000, 32'd3, 32'd4, 5'd17, 32'd12, 33, 1'b1); wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
`default_nettype wire
